// File: rtl/fpmul_iter_pkg.sv
// Shared types and sizing helpers for the iterative fixed-point multiplier.
//   state_e     : controller state encoding (IDLE, CALC, DONE)
//   digit_count : number of K-bit multiplier digits in an N-bit operand
//   cnt_width   : digit counter width, never narrower than one bit
package fpmul_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned digit_count(input int unsigned n, input int unsigned k);
        return n / k;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n, input int unsigned k);
        return (n / k > 1) ? $clog2(n / k) : 1;
    endfunction

endpackage

// File: rtl/fpmul_iter_dp.sv
// Datapath of fpmul_iter: accumulator, digit select, partial products,
// rounding, overflow detection and optional saturation.
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the accumulator (operand acceptance)
//   step       : retire digit 'cnt' of b into the accumulator
//   last       : current digit is the most significant one
//   cnt        : digit index
//   a_ext      : multiplicand, already extended to 2N bits
//   b          : multiplier
//   c, ovf     : registered result and overflow flag, loaded on the last step
// Build option FPMUL_ITER_SAT_EN: saturate c when ovf is set.
module fpmul_iter_dp
    import fpmul_iter_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned D     = 16,
    parameter int unsigned K     = 2,
    parameter int unsigned SIGN  = 1,
    parameter int unsigned ROUND = 0,
    parameter int unsigned CW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             step,
    input  logic             last,
    input  logic [CW-1:0]    cnt,
    input  logic [2*N-1:0]   a_ext,
    input  logic [N-1:0]     b,
    output logic [N-1:0]     c,
    output logic             ovf
);

    localparam int unsigned W2 = 2 * N;
    localparam logic [W2-1:0] RND_ADD =
        (ROUND != 0 && D >= 1) ? (W2'(1) << ((D >= 1) ? D - 1 : 0)) : '0;
    localparam logic [W2-1:0] ONES = '1;

`ifdef FPMUL_ITER_SAT_EN
    localparam logic [N-1:0] SAT_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_NEG = {1'b1, {(N-1){1'b0}}};
`endif

    logic [W2-1:0] acc;
    logic [K-1:0]  digit_c;
    logic [W2-1:0] pp_c;
    logic [W2-1:0] acc_next_c;
    logic [W2-1:0] prod_c;
    logic [W2-1:0] hi_c;
    logic [N-1:0]  res_c;
    logic          ovf_c;

    // Partial product for the current digit and the rounded final product
    always_comb begin
        digit_c = K'(b >> (32'(cnt) * K));
        pp_c    = a_ext * W2'(digit_c);
        // Top digit of a signed multiplier carries weight -2^(K-1) on its MSB
        if (SIGN != 0 && last && digit_c[K-1]) begin
            pp_c = pp_c - (a_ext << K);
        end
        acc_next_c = acc + (pp_c << (32'(cnt) * K));
        prod_c     = acc_next_c + RND_ADD;

        if (SIGN != 0) begin
            hi_c  = prod_c >> (N + D - 1);
            ovf_c = !((hi_c == '0) || (hi_c == (ONES >> (N + D - 1))));
        end else begin
            hi_c  = prod_c >> (N + D);
            ovf_c = (hi_c != '0);
        end

        res_c = N'(prod_c >> D);
`ifdef FPMUL_ITER_SAT_EN
        if (ovf_c) begin
            if (SIGN != 0) begin
                res_c = prod_c[W2-1] ? SAT_NEG : SAT_POS;
            end else begin
                res_c = '1;
            end
        end
`endif
    end

    // Accumulator and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            c   <= '0;
            ovf <= 1'b0;
        end else begin
            if (clear) begin
                acc <= '0;
            end else if (step) begin
                acc <= acc_next_c;
            end
            if (step && last) begin
                c   <= res_c;
                ovf <= ovf_c;
            end
        end
    end

endmodule

// File: rtl/fpmul_iter.sv
// Iterative fixed-point multiplier c = a*b on Q(N-D).D operands, K
// multiplier bits per cycle, val/rdy on both sides.
//   clk, reset       : clock, synchronous active-high reset
//   snd_val, snd_rdy : operand handshake (a, b)
//   rcv_val, rcv_rdy : result handshake (c, ovf)
// Build option FPMUL_ITER_SAT_EN: saturate c on overflow instead of wrapping.
module fpmul_iter
    import fpmul_iter_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned D     = 16,
    parameter int unsigned K     = 2,
    parameter int unsigned SIGN  = 1,
    parameter int unsigned ROUND = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         snd_val,
    output logic         snd_rdy,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         rcv_val,
    input  logic         rcv_rdy,
    output logic [N-1:0] c,
    output logic         ovf
);

    localparam int unsigned NDIG = digit_count(N, K);
    localparam int unsigned CW   = cnt_width(N, K);
    localparam int unsigned W2   = 2 * N;

    state_e          state;
    state_e          state_next;
    logic [CW-1:0]   cnt;
    logic [W2-1:0]   a_reg;
    logic [N-1:0]    b_reg;
    logic            start_c;
    logic            step_c;
    logic            last_c;
    logic            a_sign_c;

    assign last_c   = (cnt == CW'(NDIG - 1));
    assign a_sign_c = (SIGN != 0) && a[N-1];

    // Next-state and control strobes
    always_comb begin
        state_next = state;
        start_c    = 1'b0;
        step_c     = 1'b0;
        case (state)
            IDLE: begin
                if (snd_val) begin
                    start_c    = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                step_c = 1'b1;
                if (last_c) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (rcv_rdy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, registered handshake outputs, operands and digit counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            snd_rdy <= 1'b1;
            rcv_val <= 1'b0;
            cnt     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
        end else begin
            state   <= state_next;
            snd_rdy <= (state_next == IDLE);
            rcv_val <= (state_next == DONE);
            if (start_c) begin
                a_reg <= {{N{a_sign_c}}, a};
                b_reg <= b;
                cnt   <= '0;
            end else if (step_c) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    fpmul_iter_dp #(
        .N     (N),
        .D     (D),
        .K     (K),
        .SIGN  (SIGN),
        .ROUND (ROUND),
        .CW    (CW)
    ) u_dp (
        .clk   (clk),
        .reset (reset),
        .clear (start_c),
        .step  (step_c),
        .last  (last_c),
        .cnt   (cnt),
        .a_ext (a_reg),
        .b     (b_reg),
        .c     (c),
        .ovf   (ovf)
    );

endmodule

// File: doc/fpmul_iter.md
# fpmul_iter

Parametrised fixed-point iterative multiplier computing c = a*b on two's-complement (or unsigned) Q(N-D).D operands. It retires K multiplier bits per cycle and supports configurable rounding, an overflow flag and synchronous reset. It sits between val/rdy producers and consumers in the DSP datapath (FFT butterflies, filters) wherever area matters more than throughput.

## Interface
- N, 32, operand/result width in bits
- D, 16, fractional bits; 0 <= D < N
- K, 2, multiplier bits retired per cycle; N % K == 0 required
- SIGN, 1, 1 = signed two's complement, 0 = unsigned
- ROUND, 0, 0 = truncate (floor), 1 = round to nearest, ties toward +inf; requires D >= 1

- clk  input  1  clock, all state on posedge
- reset  input  1  synchronous, active-high
- snd_val  input  1  operands valid
- snd_rdy  output  1  block can accept operands
- a  input  N  multiplicand
- b  input  N  multiplier
- rcv_val  output  1  result valid
- rcv_rdy  input  1  consumer accepts result
- c  output  N  result
- ovf  output  1  true result not representable in N bits; valid with rcv_val

## Operation
- FSM states IDLE, CALC, DONE.
- IDLE: snd_rdy=1. On snd_val: latch a (sign-extended to 2N if SIGN) and b, clear 2N-bit accumulator and digit counter, go CALC.
- CALC: snd_rdy=0, rcv_val=0. Each cycle take K-bit digit i of b (LSB first); add (a * digit) << (i*K) into accumulator. If SIGN, top digit is signed (MSB weight negative), so its partial product is subtracted accordingly. Counter increments; after digit N/K-1 go DONE.
- DONE: rcv_val=1, c/ovf stable. On rcv_rdy go IDLE. Inputs ignored.
- Result: P = full 2N-bit product. If ROUND, P += 1 << (D-1). c = P[N+D-1:D].
- ovf: SIGN: bits P[2N-1:N+D-1] not all equal; unsigned: P[2N-1:N+D] nonzero. Evaluated after rounding.
- Operand registers hold their values during CALC; changes on a/b after acceptance have no effect.

## Timing
- Reset values: snd_rdy=1 (state IDLE), rcv_val=0, c=0, ovf=0, accumulator/counter 0.
- Reset in any state: next cycle is IDLE; no partial or stale result is ever presented.
- Latency: operands accepted on edge E; rcv_val rises after edge E+N/K.
- Result stays valid until the cycle rcv_rdy=1; IDLE follows on the next edge; snd_rdy re-asserts then.
- Throughput: one product per N/K+2 cycles minimum; no input/output overlap (snd_rdy and rcv_val never both 1).
- snd_val while snd_rdy=0: ignored, not queued.

## Configuration
- FPMUL_ITER_SAT_EN defined: when ovf=1, c saturates to the most positive/most negative representable value (signed, by sign of P) or all-ones (unsigned); ovf still reported.
- Undefined: c is the wrapped value P[N+D-1:D]; ovf reported.

## Structure
- Package fpmul_iter_pkg: FSM state enum typedef; function returning digit count N/K; localparam helpers for counter width ($clog2(N/K)).
- Sub-module fpmul_iter_dp: accumulator, digit select, partial-product generation, round/saturate/ovf logic; parent holds FSM, handshake and operand registers.

## Test plan
- N=16,D=8,K=2,SIGN=1: a=0x0180 (1.5), b=0x0200 (2.0) -> c=0x0300, ovf=0, rcv_val rises exactly 8 cycles after acceptance.
- Same config: a=0xFE80 (-1.5), b=0x0200 -> c=0xFD00; a=0xFE80, b=0xFE00 (-2.0) -> c=0x0300.
- Rounding: a=0x0001, b=0x0080 -> ROUND=0: c=0x0000; ROUND=1: c=0x0001; a=0xFFFF, b=0x0080, ROUND=0 -> c=0xFFFF.
- Overflow: a=0x7F00, b=0x0200 -> ovf=1; without FPMUL_ITER_SAT_EN c=0xFE00, with it c=0x7FFF; a=0x8000, b=0x0200 saturates to 0x8000.
- Back-pressure: hold rcv_rdy=0 for 5 cycles -> c/rcv_val stable, snd_rdy=0, new snd_val ignored; release -> IDLE next cycle, snd_rdy=1.
- Reset asserted during 3rd CALC cycle -> next cycle snd_rdy=1, rcv_val=0, c=0; subsequent 0x0100*0x0100 yields 0x0100 with full latency. Sweep K in {1,2,4,16} with random operands vs. reference model.
